ppi_sync: RTL

Parametrised, synchronous successor to the team's 8255-style programmable peripheral interface. Provides `NPORTS` independent `WIDTH`-bit peripheral ports behind a single-clock host register interface. Each port is configured individually as input or output, in basic mode (mode 0) or strobed handshake mode (mode 1), with per-bit set/reset, handshake status flags and an interrupt output. Sits between the host bus and external peripherals, with separate in/out/output-enable buses in place of internal tri-states.

---
 rtl/ppi_sync_pkg.sv | 33 +++
 rtl/ppi_sync_port.sv | 161 ++++++++++++++++
 rtl/ppi_sync.sv | 81 ++++++++
 3 files changed

// File: rtl/ppi_sync_pkg.sv
// ppi_sync_pkg: shared encodings for the ppi_sync host register map.
// Holds the sel field codes, CFG/STATUS bit positions, BSR field layout
// and the CFG reset value.
package ppi_sync_pkg;

    // sel field of addr
    localparam logic [1:0] SEL_DATA   = 2'd0;
    localparam logic [1:0] SEL_CFG    = 2'd1;
    localparam logic [1:0] SEL_BSR    = 2'd2;
    localparam logic [1:0] SEL_STATUS = 2'd3;

    // CFG bit positions
    localparam int unsigned CFG_DIR  = 0;
    localparam int unsigned CFG_MODE = 1;
    localparam int unsigned CFG_IE   = 2;
    localparam int unsigned CFG_W    = 3;

    localparam logic [CFG_W-1:0] CFG_RESET = 3'b001;

    // STATUS bit positions
    localparam int unsigned STAT_DIR  = 0;
    localparam int unsigned STAT_MODE = 1;
    localparam int unsigned STAT_IBF  = 2;
    localparam int unsigned STAT_OBF  = 3;
    localparam int unsigned STAT_INTR = 4;
    localparam int unsigned STAT_OVR  = 5;

    // BSR write fields
    localparam int unsigned BSR_IDX_LSB = 0;
    localparam int unsigned BSR_IDX_W   = 4;
    localparam int unsigned BSR_VAL     = 4;

endpackage

// File: rtl/ppi_sync_port.sv
// ppi_sync_port: one peripheral port of ppi_sync.
// Holds CFG, the output latch, the strobed input buffer, stb/ack/port_in
// synchronisers, handshake flags and the per-port read mux.
// Ports: clk/reset; cfg_wr/data_wr/bsr_wr/data_rd are already-decoded
// host strobes for this port; sel picks the read mux source (rd_data_c);
// port_in/stb/ack come from the peripheral; port_out/port_oe/ibf/obf/intr
// are registered outputs.
module ppi_sync_port
    import ppi_sync_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_wr,
    input  logic             data_wr,
    input  logic             bsr_wr,
    input  logic             data_rd,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0] port_in,
    input  logic             stb,
    input  logic             ack,
    output logic [WIDTH-1:0] port_out,
    output logic             port_oe,
    output logic             ibf,
    output logic             obf,
    output logic             intr,
    output logic [WIDTH-1:0] rd_data_c
);

    logic [CFG_W-1:0] cfg_q, cfg_n;
    logic [WIDTH-1:0] latch_q, latch_n, buf_q, buf_n;
    logic             ibf_q, ibf_n, obf_q, obf_n, done_q, done_n, ovr_q, ovr_n;
    logic             intr_q, intr_n, oe_q, oe_n;
    logic [WIDTH-1:0] pin_s1, pin_s2;
    logic             stb_s1, stb_s2, stb_d, ack_s1, ack_s2, ack_d;
    logic             stb_edge, ack_edge, m1_in, m1_out;
    logic [BSR_IDX_W-1:0] bsr_idx;

    assign stb_edge = stb_s2 & ~stb_d;
    assign ack_edge = ack_s2 & ~ack_d;
    assign m1_in    = cfg_q[CFG_MODE] & cfg_q[CFG_DIR];
    assign m1_out   = cfg_q[CFG_MODE] & ~cfg_q[CFG_DIR];
    assign bsr_idx  = wdata[BSR_IDX_LSB +: BSR_IDX_W];

    // Next-state: host events, then handshake events, CFG write overrides flags
    always_comb begin
        cfg_n   = cfg_q;
        latch_n = latch_q;
        buf_n   = buf_q;
        ibf_n   = ibf_q;
        obf_n   = obf_q;
        done_n  = done_q;
        ovr_n   = ovr_q;

        if (data_wr) begin
            latch_n = wdata;
            if (m1_out) begin
                obf_n  = 1'b1;
                done_n = 1'b0;
            end
        end

        if (bsr_wr) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (32'(bsr_idx) == i) latch_n[i] = wdata[BSR_VAL];
            end
        end

        if (data_rd && m1_in) ibf_n = 1'b0;

        // A read in the same cycle frees the buffer for the new strobe
        if (stb_edge && m1_in) begin
            if (ibf_q && !data_rd) begin
                ovr_n = 1'b1;
            end else begin
                buf_n = pin_s2;
                ibf_n = 1'b1;
            end
        end

        // A simultaneous host write keeps the buffer full
        if (ack_edge && m1_out && obf_q && !data_wr) begin
            obf_n  = 1'b0;
            done_n = 1'b1;
        end

        if (cfg_wr) begin
            cfg_n  = wdata[CFG_W-1:0];
            ibf_n  = 1'b0;
            obf_n  = 1'b0;
            done_n = 1'b0;
            ovr_n  = 1'b0;
        end

        intr_n = cfg_n[CFG_IE] & cfg_n[CFG_MODE] & (cfg_n[CFG_DIR] ? ibf_n : done_n);
        oe_n   = ~cfg_n[CFG_DIR];
    end

    // State and synchroniser registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_q   <= CFG_RESET;
            latch_q <= '0;
            buf_q   <= '0;
            ibf_q   <= 1'b0;
            obf_q   <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            intr_q  <= 1'b0;
            oe_q    <= 1'b0;
            pin_s1  <= '0;
            pin_s2  <= '0;
            stb_s1  <= 1'b0;
            stb_s2  <= 1'b0;
            stb_d   <= 1'b0;
            ack_s1  <= 1'b0;
            ack_s2  <= 1'b0;
            ack_d   <= 1'b0;
        end else begin
            cfg_q   <= cfg_n;
            latch_q <= latch_n;
            buf_q   <= buf_n;
            ibf_q   <= ibf_n;
            obf_q   <= obf_n;
            done_q  <= done_n;
            ovr_q   <= ovr_n;
            intr_q  <= intr_n;
            oe_q    <= oe_n;
            pin_s1  <= port_in;
            pin_s2  <= pin_s1;
            stb_s1  <= stb;
            stb_s2  <= stb_s1;
            stb_d   <= stb_s2;
            ack_s1  <= ack;
            ack_s2  <= ack_s1;
            ack_d   <= ack_s2;
        end
    end

    // Per-port read mux
    always_comb begin
        rd_data_c = '0;
        case (sel)
            SEL_DATA:   rd_data_c = cfg_q[CFG_DIR] ? (cfg_q[CFG_MODE] ? buf_q : pin_s2) : latch_q;
            SEL_CFG:    rd_data_c = WIDTH'(cfg_q);
            SEL_BSR:    rd_data_c = latch_q;
            SEL_STATUS: rd_data_c = WIDTH'({ovr_q, intr_q, obf_q, ibf_q,
                                            cfg_q[CFG_MODE], cfg_q[CFG_DIR]});
            default:    rd_data_c = '0;
        endcase
    end

    assign port_out = latch_q;
    assign port_oe  = oe_q;
    assign ibf      = ibf_q;
    assign obf      = obf_q;
    assign intr     = intr_q;

endmodule

// File: rtl/ppi_sync.sv
// ppi_sync: NPORTS-port programmable peripheral interface, host side.
// Decodes addr = {sel, port} into per-port strobes, registers rdata.
// Ports: clk, reset, cs/rd/wr/addr/wdata/rdata host bus; port_in/port_out/
// port_oe peripheral pins (port p at [p*WIDTH +: WIDTH]); stb/ack handshake
// inputs; ibf/obf/intr per-port status outputs.
module ppi_sync
    import ppi_sync_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NPORTS = 3,
    parameter int unsigned PW     = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cs,
    input  logic                    rd,
    input  logic                    wr,
    input  logic [PW+1:0]           addr,
    input  logic [WIDTH-1:0]        wdata,
    output logic [WIDTH-1:0]        rdata,
    input  logic [NPORTS*WIDTH-1:0] port_in,
    output logic [NPORTS*WIDTH-1:0] port_out,
    output logic [NPORTS-1:0]       port_oe,
    input  logic [NPORTS-1:0]       stb,
    input  logic [NPORTS-1:0]       ack,
    output logic [NPORTS-1:0]       ibf,
    output logic [NPORTS-1:0]       obf,
    output logic [NPORTS-1:0]       intr
);

    logic [1:0]       sel;
    logic [PW-1:0]    psel;
    logic             wr_ok, rd_ok;
    logic [WIDTH-1:0] rd_arr [NPORTS];
    logic [WIDTH-1:0] rd_mux_c;

    assign sel   = addr[PW+1:PW];
    assign psel  = addr[PW-1:0];
    assign wr_ok = cs & wr;
    // A write in the same cycle suppresses the read and its side effects
    assign rd_ok = cs & rd & ~wr;

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        logic hit;
        assign hit = (psel == PW'(p));

        ppi_sync_port #(.WIDTH(WIDTH)) u_port (
            .clk       (clk),
            .reset     (reset),
            .cfg_wr    (wr_ok & hit & (sel == SEL_CFG)),
            .data_wr   (wr_ok & hit & (sel == SEL_DATA)),
            .bsr_wr    (wr_ok & hit & (sel == SEL_BSR)),
            .data_rd   (rd_ok & hit & (sel == SEL_DATA)),
            .sel       (sel),
            .wdata     (wdata),
            .port_in   (port_in[p*WIDTH +: WIDTH]),
            .stb       (stb[p]),
            .ack       (ack[p]),
            .port_out  (port_out[p*WIDTH +: WIDTH]),
            .port_oe   (port_oe[p]),
            .ibf       (ibf[p]),
            .obf       (obf[p]),
            .intr      (intr[p]),
            .rd_data_c (rd_arr[p])
        );
    end

    // Port select for read data; unmapped port numbers read as zero
    always_comb begin
        rd_mux_c = '0;
        for (int unsigned p = 0; p < NPORTS; p++) begin
            if (psel == PW'(p)) rd_mux_c = rd_arr[p];
        end
    end

    always_ff @(posedge clk) begin
        if (reset)      rdata <= '0;
        else if (rd_ok) rdata <= rd_mux_c;
    end

endmodule
